// File: rtl/reduce_engine.sv
// reduce_engine: in-network reduction engine for the MPI collective router.
// Each table entry, indexed by the low tag bits, collects the contributions of
// one reduction. Contributions are folded through a shared pipelined ALU, and
// the entry is emitted as one combined flit once every child has reported.
//
// Flit layout, LSB first:
//   payload[PW] op[4] algtype[2] tag[16] ctx[9] rank[6] src[6] dst[6] valid[1]
// The children count sits directly above the flit valid bit on the input side.
module reduce_engine #(
    parameter int PayloadWidth  = 32,
    parameter int lg_numprocs   = 3,
    parameter int LgTableDepth  = 2,
    parameter int AluLatency    = 4,
    localparam int FlitWidth     = PayloadWidth + 50,
    localparam int ChildrenWidth = lg_numprocs
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [FlitWidth+ChildrenWidth-1:0] in_flit,
    input  logic                               in_valid,
    output logic                               in_ready,
    output logic [FlitWidth-1:0]               out_flit,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic                               done,
    output logic [LgTableDepth:0]              busy_entries,
    output logic [15:0]                        drop_count
);

    localparam int PW      = PayloadWidth;
    localparam int FW      = FlitWidth;
    localparam int CW      = ChildrenWidth;
    localparam int IdxW    = LgTableDepth;
    localparam int Depth   = 1 << LgTableDepth;
    localparam int OP_LO   = PW;
    localparam int ALG_LO  = PW + 4;
    localparam int TAG_LO  = PW + 6;
    localparam int VLD_BIT = FW - 1;

    typedef enum logic [1:0] {
        FREE  = 2'd0,
        ACCUM = 2'd1,
        BUSY  = 2'd2,
        DONE  = 2'd3
    } ent_state_e;

    // Reduction operator selected by the entry's stored algtype.
    function automatic logic signed [PW-1:0] alu_op(
        input logic [1:0]           sel,
        input logic signed [PW-1:0] a,
        input logic signed [PW-1:0] b
    );
        logic signed [PW-1:0] r;
        case (sel)
            2'b00:   r = a + b;
            2'b01:   r = (a > b) ? a : b;
            2'b10:   r = (a < b) ? a : b;
            default: r = a ^ b;
        endcase
        return r;
    endfunction

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] cnt);
        return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
    endfunction

    // Rewrite a completed entry into its outgoing form: LargeReduce becomes
    // Gather, algtype cleared, valid bit set; routing fields pass through.
    function automatic logic [FW-1:0] format_out(input logic [FW-1:0] f);
        logic [FW-1:0] o;
        o = f;
        o[VLD_BIT] = 1'b1;
        o[ALG_LO +: 2] = 2'b00;
        if (f[OP_LO +: 4] == 4'b1101) begin
            o[OP_LO +: 4] = 4'b1011;
        end
        return o;
    endfunction

    // Entry table
    ent_state_e        state_q     [Depth];
    ent_state_e        state_d     [Depth];
    logic [CW-1:0]     remaining_q [Depth];
    logic [CW-1:0]     remaining_d [Depth];
    logic [FW-1:0]     flit_q      [Depth];
    logic [FW-1:0]     flit_d      [Depth];

    // ALU pipeline: index 0 is captured on the launch edge, the last stage
    // writes back on the following edge.
    logic                 vld_p_q [AluLatency];
    logic                 vld_p_d [AluLatency];
    logic [IdxW-1:0]      idx_p_q [AluLatency];
    logic [IdxW-1:0]      idx_p_d [AluLatency];
    logic signed [PW-1:0] res_p_q [AluLatency];
    logic signed [PW-1:0] res_p_d [AluLatency];

    // Output hold: once a presented entry is stalled its index is frozen so a
    // lower-index entry finishing later cannot steal the output slot.
    logic            lock_q, lock_d;
    logic [IdxW-1:0] lock_idx_q, lock_idx_d;
    logic            done_q, done_d;
    logic [15:0]     drop_q, drop_d;

    logic [FW-1:0]   in_fl;
    logic [CW-1:0]   in_children;
    logic [IdxW-1:0] in_idx;
    logic            is_reduce;
    logic            accept;
    logic            any_done;
    logic [IdxW-1:0] first_idx;
    logic [IdxW-1:0] sel_idx;
    logic            out_hs;
    logic [IdxW:0]   busy_cnt;
    logic [IdxW-1:0] wb_idx;

    // Input decode, ready, output selection and occupancy count.
    always_comb begin
        in_fl       = in_flit[FW-1:0];
        in_children = in_flit[FW+CW-1:FW];
        in_idx      = in_fl[TAG_LO +: IdxW];
        is_reduce   = in_fl[VLD_BIT] && (in_fl[OP_LO+2 +: 2] == 2'b11);
        in_ready    = !rst && (!is_reduce ||
                               (state_q[in_idx] == FREE) || (state_q[in_idx] == ACCUM));
        accept      = in_valid && in_ready;

        any_done  = 1'b0;
        first_idx = '0;
        busy_cnt  = '0;
        for (int i = Depth - 1; i >= 0; i--) begin
            if (state_q[i] == DONE) begin
                any_done  = 1'b1;
                first_idx = IdxW'(i);
            end
            if (state_q[i] != FREE) begin
                busy_cnt = busy_cnt + (IdxW+1)'(1);
            end
        end

        sel_idx      = lock_q ? lock_idx_q : first_idx;
        out_valid    = lock_q || any_done;
        out_hs       = out_valid && out_ready;
        out_flit     = out_valid ? format_out(flit_q[sel_idx]) : '0;
        busy_entries = busy_cnt;
        wb_idx       = idx_p_q[AluLatency-1];
    end

    // Next-state for entries, ALU pipeline, output hold and counters.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        flit_d      = flit_q;
        lock_d      = lock_q;
        lock_idx_d  = lock_idx_q;
        drop_d      = drop_q;
        done_d      = out_hs;

        vld_p_d[0] = 1'b0;
        idx_p_d[0] = in_idx;
        res_p_d[0] = alu_op(flit_q[in_idx][ALG_LO +: 2],
                            flit_q[in_idx][PW-1:0], in_fl[PW-1:0]);
        for (int k = 1; k < AluLatency; k++) begin
            vld_p_d[k] = vld_p_q[k-1];
            idx_p_d[k] = idx_p_q[k-1];
            res_p_d[k] = res_p_q[k-1];
        end

        if (vld_p_q[AluLatency-1]) begin
            flit_d[wb_idx][PW-1:0] = res_p_q[AluLatency-1];
            remaining_d[wb_idx]    = remaining_q[wb_idx] - CW'(1);
            state_d[wb_idx]        = (remaining_q[wb_idx] == CW'(1)) ? DONE : ACCUM;
        end

        if (accept) begin
            if (!is_reduce) begin
                drop_d = sat_inc16(drop_q);
            end else if (state_q[in_idx] == FREE) begin
                flit_d[in_idx]      = in_fl;
                remaining_d[in_idx] = in_children;
                state_d[in_idx]     = (in_children == '0) ? DONE : ACCUM;
            end else begin
                vld_p_d[0]      = 1'b1;
                state_d[in_idx] = BUSY;
            end
        end

        if (out_hs) begin
            state_d[sel_idx] = FREE;
            lock_d           = 1'b0;
        end else if (out_valid) begin
            lock_d     = 1'b1;
            lock_idx_d = sel_idx;
        end
    end

    // Control state: cleared asynchronously, dropping any in-flight results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < Depth; i++) begin
                state_q[i]     <= FREE;
                remaining_q[i] <= '0;
            end
            for (int k = 0; k < AluLatency; k++) begin
                vld_p_q[k] <= 1'b0;
            end
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            done_q     <= 1'b0;
            drop_q     <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            vld_p_q     <= vld_p_d;
            lock_q      <= lock_d;
            lock_idx_q  <= lock_idx_d;
            done_q      <= done_d;
            drop_q      <= drop_d;
        end
    end

    // Datapath storage: qualified by the control state, so no reset needed.
    always_ff @(posedge clk) begin
        flit_q  <= flit_d;
        idx_p_q <= idx_p_d;
        res_p_q <= res_p_d;
    end

    assign done       = done_q;
    assign drop_count = drop_q;

endmodule
